// File: rtl/matmul_sequencer.sv
// Sequencer computing C = A x B (3x3) through a single register-memory port.
// Optional MATMUL_SATURATE_EN: clamp written elements to 2^DATA_W-1 instead of wrapping.
module matmul_sequencer #(
    parameter int unsigned SRC_A  = 0,
    parameter int unsigned SRC_B  = 1,
    parameter int unsigned DST    = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [1:0]        mem_matrix_select,
    output logic [1:0]        mem_row,
    output logic [1:0]        mem_col,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned ACC_W = 2 * DATA_W + 2;
    localparam logic [ACC_W-1:0] MAX_VAL = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_t;

    state_t             state, state_n;
    logic [1:0]         i, j, k, i_n, j_n, k_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [DATA_W-1:0]  a_reg, a_n;
    logic               ovf_n, busy_n, done_n, rd_n, we_n;
    logic [1:0]         sel_n, row_n, col_n;
    logic [DATA_W-1:0]  wdata_n;

    // Next state, datapath, and memory-port decode of the upcoming state
    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        k_n     = k;
        acc_n   = acc;
        a_n     = a_reg;
        ovf_n   = ovf;
        rd_n    = 1'b0;
        we_n    = 1'b0;
        sel_n   = 2'd0;
        row_n   = 2'd0;
        col_n   = 2'd0;
        wdata_n = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    i_n     = 2'd0;
                    j_n     = 2'd0;
                    k_n     = 2'd0;
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = RD_A;
                end
            end
            RD_A: state_n = RD_B;
            RD_B: begin
                a_n     = mem_read_data;
                state_n = MAC;
            end
            MAC: begin
                acc_n = acc + ACC_W'(a_reg) * ACC_W'(mem_read_data);
                if (k == 2'd2) begin
                    k_n     = 2'd0;
                    state_n = WR;
                end else begin
                    k_n     = k + 2'd1;
                    state_n = RD_A;
                end
            end
            WR: begin
                if (acc > MAX_VAL) ovf_n = 1'b1;
                acc_n = '0;
                if (j == 2'd2) begin
                    j_n = 2'd0;
                    i_n = (i == 2'd2) ? 2'd0 : i + 2'd1;
                end else begin
                    j_n = j + 2'd1;
                end
                state_n = (i == 2'd2 && j == 2'd2) ? DONE : RD_A;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Port values are precomputed so they appear registered in the matching state
        case (state_n)
            RD_A: begin
                rd_n  = 1'b1;
                sel_n = 2'(SRC_A);
                row_n = i_n;
                col_n = k_n;
            end
            RD_B: begin
                rd_n  = 1'b1;
                sel_n = 2'(SRC_B);
                row_n = k_n;
                col_n = j_n;
            end
            WR: begin
                we_n  = 1'b1;
                sel_n = 2'(DST);
                row_n = i_n;
                col_n = j_n;
`ifdef MATMUL_SATURATE_EN
                wdata_n = (acc_n > MAX_VAL) ? {DATA_W{1'b1}} : acc_n[DATA_W-1:0];
`else
                wdata_n = acc_n[DATA_W-1:0];
`endif
            end
            default: ;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            i                 <= 2'd0;
            j                 <= 2'd0;
            k                 <= 2'd0;
            acc               <= '0;
            a_reg             <= '0;
            ovf               <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            mem_matrix_select <= 2'd0;
            mem_row           <= 2'd0;
            mem_col           <= 2'd0;
            mem_write_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            mem_write_data    <= '0;
        end else begin
            state             <= state_n;
            i                 <= i_n;
            j                 <= j_n;
            k                 <= k_n;
            acc               <= acc_n;
            a_reg             <= a_n;
            ovf               <= ovf_n;
            busy              <= busy_n;
            done              <= done_n;
            mem_matrix_select <= sel_n;
            mem_row           <= row_n;
            mem_col           <= col_n;
            mem_write_enable  <= we_n;
            mem_read_enable   <= rd_n;
            mem_write_data    <= wdata_n;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: memory model, matrix-product reference, timing and port-usage checks.
module tb_matmul_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, ovf;
    logic [1:0] mem_matrix_select, mem_row, mem_col;
    logic       mem_write_enable, mem_read_enable;
    logic [7:0] mem_write_data;
    logic [7:0] rdata;

    logic [7:0] mat_a [3][3];
    logic [7:0] mat_b [3][3];
    logic [7:0] mat_c [3][3];
    logic [7:0] exp_c [3][3];
    logic       exp_ovf;

    int vectors = 0;
    int miscompares = 0;
    int n_wr = 0, n_rda = 0, n_rdb = 0, n_both = 0, n_done = 0;
    logic mon_clr = 1'b0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .ovf               (ovf),
        .mem_matrix_select (mem_matrix_select),
        .mem_row           (mem_row),
        .mem_col           (mem_col),
        .mem_write_enable  (mem_write_enable),
        .mem_read_enable   (mem_read_enable),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (rdata)
    );

    // Register memory: registered read data, zero when not reading
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= '0;
            if (mem_read_enable) begin
                case (mem_matrix_select)
                    2'd0:    rdata <= mat_a[mem_row][mem_col];
                    2'd1:    rdata <= mat_b[mem_row][mem_col];
                    2'd2:    rdata <= mat_c[mem_row][mem_col];
                    default: rdata <= '0;
                endcase
            end
            if (mem_write_enable && mem_matrix_select == 2'd2)
                mat_c[mem_row][mem_col] <= mem_write_data;
        end
    end

    // Port activity counters, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_clr) begin
            n_wr <= 0; n_rda <= 0; n_rdb <= 0; n_both <= 0; n_done <= 0;
        end else begin
            if (mem_write_enable) n_wr <= n_wr + 1;
            if (mem_read_enable && mem_matrix_select == 2'd0) n_rda <= n_rda + 1;
            if (mem_read_enable && mem_matrix_select == 2'd1) n_rdb <= n_rdb + 1;
            if (mem_read_enable && mem_write_enable) n_both <= n_both + 1;
            if (done) n_done <= n_done + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain 3x3 matrix product, then wrap or clamp to 8 bits
    task automatic compute_expected();
        exp_ovf = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int unsigned s;
                s = 0;
                for (int x = 0; x < 3; x++) s += mat_a[r][x] * mat_b[x][c];
                if (s > 255) exp_ovf = 1'b1;
`ifdef MATMUL_SATURATE_EN
                exp_c[r][c] = (s > 255) ? 8'd255 : 8'(s);
`else
                exp_c[r][c] = 8'(s);
`endif
            end
    endtask

    task automatic fill_rand(input int unsigned maxv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mat_a[r][c] = 8'($urandom_range(maxv, 0));
                mat_b[r][c] = 8'($urandom_range(maxv, 0));
            end
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mat_a[r][c] = av;
                mat_b[r][c] = bv;
            end
    endtask

    task automatic check_c(input string tag);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("%s_c%0d%0d", tag, r, c), 32'(mat_c[r][c]), 32'(exp_c[r][c]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_ovf"},   32'(ovf), 0);
        check({tag, "_rd"},    32'(mem_read_enable), 0);
        check({tag, "_we"},    32'(mem_write_enable), 0);
        check({tag, "_sel"},   32'(mem_matrix_select), 0);
        check({tag, "_row"},   32'(mem_row), 0);
        check({tag, "_col"},   32'(mem_col), 0);
        check({tag, "_wdata"}, 32'(mem_write_data), 0);
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    // One complete run; optionally pulses start at cycles 5 and 60 of the run
    task automatic run_check(input string tag, input bit glitch);
        int cyc;
        bit got;
        compute_expected();
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 1);
        check({tag, "_ovf_clr"}, 32'(ovf), 0);
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            start = glitch && (cyc == 5 || cyc == 60);
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(cyc), 90);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_busy_off"}, 32'(busy), 0);
        check({tag, "_done_pulses"}, 32'(n_done), 1);
        check({tag, "_writes"}, 32'(n_wr), 9);
        check({tag, "_reads_a"}, 32'(n_rda), 27);
        check({tag, "_reads_b"}, 32'(n_rdb), 27);
        check({tag, "_both_en"}, 32'(n_both), 0);
        check_c(tag);
    endtask

    initial begin
        int cyc, done_cyc, restart;
        bit seen_idle;

        // Reset state
        @(posedge clk); #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity times 1..9
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mat_a[r][c] = (r == c) ? 8'd1 : 8'd0;
                mat_b[r][c] = 8'(r * 3 + c + 1);
            end
        run_check("ident", 1'b0);

        fill_const(8'd2, 8'd3);
        run_check("const23", 1'b0);

        fill_const(8'd200, 8'd200);
        run_check("ovf200", 1'b0);

        fill_rand(15);
        run_check("rand_small", 1'b0);

        fill_rand(255);
        run_check("glitch", 1'b1);

        for (int n = 0; n < 3; n++) begin
            fill_rand(n == 0 ? 40 : 255);
            run_check($sformatf("rand%0d", n), 1'b0);
        end

        // Asynchronous reset in the middle of an overflowing run
        fill_const(8'd200, 8'd200);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrun_ovf_set", 32'(ovf), 1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midrun_rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        fill_rand(255);
        run_check("after_rst", 1'b0);

        // Start held high: back-to-back runs
        fill_rand(255);
        compute_expected();
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        done_cyc = -1;
        restart = -1;
        seen_idle = 1'b0;
        while (cyc < 300 && restart < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (!busy) seen_idle = 1'b1;
            else if (seen_idle) restart = cyc;
        end
        start = 1'b0;
        check("held_done_cycle", 32'(done_cyc), 90);
        check("held_restart_cycle", 32'(restart), 92);
        check_c("held_run1");
        cyc = 0;
        while (cyc < 200 && !done) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_run2_done_cycle", 32'(cyc), 90);
        @(posedge clk); #1;
        check("held_done_pulses", 32'(n_done), 2);
        check("held_busy_off", 32'(busy), 0);
        check_c("held_run2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Compute engine that sits directly upstream of the 3-matrix register memory and drives its port: reads operand matrices A and B and writes C = A x B back into the third slot.
- Single memory port, strictly sequential: one read or one write per cycle.
- Started by a one-cycle `start` from the top-level control.
- Reports completion with a `done` pulse and a sticky overflow flag.

Parameters:
- SRC_A, 0, matrix_select index of operand A
- SRC_B, 1, matrix_select index of operand B
- DST, 2, matrix_select index of result C
- DATA_W, 8, element width; the accumulator is 2*DATA_W+2 bits (18 at default)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when C is fully written
- ovf  out  1  sticky: some element of the current run exceeded 2^DATA_W-1; cleared when start is accepted
- mem_matrix_select  out  2  to memory matrix_select
- mem_row  out  2  to memory row
- mem_col  out  2  to memory col
- mem_write_enable  out  1  to memory write_enable
- mem_read_enable  out  1  to memory read_enable
- mem_write_data  out  DATA_W  to memory write_data
- mem_read_data  in  DATA_W  from memory read_data; registered, valid the cycle after read_enable, 0 otherwise

Behaviour:
- Reset (async, low): state=IDLE; i, j, k=0; acc=0; a_reg=0.
- Reset values: busy=0, done=0, ovf=0, all mem_* outputs 0.
- Memory-side outputs are decoded from registered state and counters only; no combinational path from `mem_read_data`.
- FSM states: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE: on start=1, clear i/j/k/acc/ovf and go to RD_A. start=0: stay.
- RD_A: read_enable=1, select=SRC_A, row=i, col=k. Go to RD_B.
- RD_B: read_enable=1, select=SRC_B, row=k, col=j. Latch a_reg <= mem_read_data at the end of the cycle. Go to MAC.
- MAC: read_enable=0; acc <= acc + a_reg*mem_read_data (unsigned).
  - If k==2: k<=0, go to WR.
  - Else: k<=k+1, go to RD_A.
- WR: write_enable=1, read_enable=0, select=DST, row=i, col=j, write_data=result(acc). If acc > 2^DATA_W-1, set ovf.
  - Then acc<=0 and advance j; on j wrap (2->0) advance i.
  - If i==2 and j==2: go to DONE, else go to RD_A.
- DONE: done=1 for this cycle, busy still 1. Go to IDLE.
- Timing: 10 cycles per element, 90 work cycles. done is high in the 91st cycle after the start-accepting edge; busy falls the cycle after.
- Element order: row-major (0,0),(0,1)...(2,2).
- mem_read_enable and mem_write_enable are never high together.
- start while not IDLE: ignored; no restart, no queuing.
- Result without the optional feature: acc[DATA_W-1:0], i.e. truncation.
- Reset mid-run: immediate return to IDLE with all outputs 0. Elements of C already written stay written. The next start recomputes all of C.
- DST equal to SRC_A or SRC_B is not supported; output is undefined. This is a documented restriction, not checked in RTL.

Optional Feature:
- Macro: MATMUL_SATURATE_EN.
- Defined: in WR, result = 2^DATA_W-1 when acc exceeds it, else acc[DATA_W-1:0].
- Undefined: result = acc[DATA_W-1:0] (wrap).
- ovf behaviour is identical in both builds.

Test Plan:
- A=identity, B=[1..9] row-major, start -> C==B in all 9 cells; done pulses exactly 91 cycles after start edge; ovf=0.
- A all 2, B all 3 -> every C cell =18; exactly 9 write strobes, 27 A reads and 27 B reads, never both enables high.
- A all 200, B all 200 (acc=120000) -> ovf=1; C cells =192 without MATMUL_SATURATE_EN, =255 with it; next start clears ovf.
- start pulsed again at cycles 5 and 60 of a run -> ignored; single done at cycle 91; C correct.
- reset low at cycle 40 of a run -> busy/done/ovf/mem_* go 0 asynchronously; a new start after release completes correctly in 91 cycles.
- start held high continuously -> back-to-back runs, each 92 cycles start-to-start (IDLE re-samples), done once per run.
